// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32 opcode constants, format decode and operand-use helpers
package rv_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
  } fmt_e;

  function automatic fmt_e op_fmt(input logic [6:0] op);
    case (op)
      OP_REG:                  return FMT_R;
      OP_LOAD, OP_IMM, OP_JALR: return FMT_I;
      OP_STORE:                return FMT_S;
      OP_BRANCH:               return FMT_B;
      OP_LUI, OP_AUIPC:        return FMT_U;
      OP_JAL:                  return FMT_J;
      default:                 return FMT_X;
    endcase
  endfunction

  // Unknown opcodes still count as rs1 readers so hazards stay conservative.
  function automatic logic uses_rs1(input fmt_e f);
    return !(f == FMT_U || f == FMT_J);
  endfunction

  function automatic logic uses_rs2(input fmt_e f);
    return (f == FMT_R || f == FMT_S || f == FMT_B);
  endfunction
endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational immediate extractor, shared with the branch unit
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (op_fmt(i_instr[6:0]))
      FMT_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
      FMT_U: w_imm32 = {i_instr[31:12], 12'b0};
      FMT_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm = XLEN'(signed'(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: field extract, WB bypass, load-use stall, ID/EX register
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int REG_AW = rv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic [REG_AW-1:0] rf_a1,
  output logic [REG_AW-1:0] rf_a2,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [XLEN-1:0]   id_pc,
  output logic [XLEN-1:0]   id_rs1_val,
  output logic [XLEN-1:0]   id_rs2_val,
  output logic [REG_AW-1:0] id_rs1,
  output logic [REG_AW-1:0] id_rs2,
  output logic [REG_AW-1:0] id_rd,
  output logic [XLEN-1:0]   id_imm,
  output logic [6:0]        id_opcode,
  output logic [2:0]        id_funct3,
  output logic              id_funct7b5,
  output logic              id_reg_write
);

  logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
  logic [6:0]        w_opcode;
  fmt_e              w_fmt;
  logic [XLEN-1:0]   w_imm;
  logic [XLEN-1:0]   w_rs1_val, w_rs2_val;
  logic              w_reg_write;
  logic              w_hazard, w_advance, w_accept;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc, r_rs1_val, r_rs2_val, r_imm;
  logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;
  logic [6:0]        r_opcode;
  logic [2:0]        r_funct3;
  logic              r_funct7b5, r_reg_write;

  assign w_rs1    = REG_AW'(if_instr[19:15]);
  assign w_rs2    = REG_AW'(if_instr[24:20]);
  assign w_rd     = REG_AW'(if_instr[11:7]);
  assign w_opcode = if_instr[6:0];
  assign w_fmt    = op_fmt(w_opcode);
  assign rf_a1    = w_rs1;
  assign rf_a2    = w_rs2;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (if_instr),
    .o_imm   (w_imm)
  );

  // The file write lands on the same edge we capture, so forward it here.
  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_rs1 != '0)
      w_rs1_val = (wb_we && wb_rd == w_rs1) ? wb_data : rf_rd1;
    if (w_rs2 != '0)
      w_rs2_val = (wb_we && wb_rd == w_rs2) ? wb_data : rf_rd2;
  end

  assign w_reg_write = (w_rd != '0) && (w_fmt != FMT_S) && (w_fmt != FMT_B)
                     && (w_fmt != FMT_X);

  assign w_hazard = ex_load && (ex_rd != '0) &&
                    ((uses_rs1(w_fmt) && ex_rd == w_rs1) ||
                     (uses_rs2(w_fmt) && ex_rd == w_rs2));

  assign w_advance = !r_valid || id_ready;
  assign if_ready  = rst || flush || (w_advance && !w_hazard);
  assign w_accept  = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_opcode    <= '0;
      r_funct3    <= '0;
      r_funct7b5  <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_pc        <= if_pc;
      r_rs1_val   <= w_rs1_val;
      r_rs2_val   <= w_rs2_val;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rd        <= w_rd;
      r_imm       <= w_imm;
      r_opcode    <= w_opcode;
      r_funct3    <= if_instr[14:12];
      r_funct7b5  <= if_instr[30];
      r_reg_write <= w_reg_write;
    end else if (w_advance) begin
      r_valid <= 1'b0;
    end
  end

  assign id_valid     = r_valid;
  assign id_pc        = r_pc;
  assign id_rs1_val   = r_rs1_val;
  assign id_rs2_val   = r_rs2_val;
  assign id_rs1       = r_rs1;
  assign id_rs2       = r_rs2;
  assign id_rd        = r_rd;
  assign id_imm       = r_imm;
  assign id_opcode    = r_opcode;
  assign id_funct3    = r_funct3;
  assign id_funct7b5  = r_funct7b5;
  assign id_reg_write = r_reg_write;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed vector bench for decode_stage
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst, if_valid, if_ready, wb_we, ex_load, flush, id_valid, id_ready;
  logic [31:0] if_instr, if_pc, rf_rd1, rf_rd2, wb_data;
  logic [4:0]  rf_a1, rf_a2, wb_rd, ex_rd;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_reg_write;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .rf_a1(rf_a1), .rf_a2(rf_a2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_load(ex_load), .ex_rd(ex_rd), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_reg_write(id_reg_write)
  );

  typedef struct {
    logic [31:0] instr, rd1, rd2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic        hz;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] v1, v2;
  } vec_t;

  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'h2222_2222;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  initial begin
    vecs[0]  = '{32'hFFD08293, D1, D2, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFD, 1, 29, 5, 1, 7'h13, 0, 1, D1, D2};
    vecs[1]  = '{32'h0021A423, D1, D2, 0, 0, 0, 0, 0, 0, 32'h8, 3, 2, 8, 0, 7'h23, 2, 0, D1, D2};
    vecs[2]  = '{32'h00018333, 32'h7, D2, 1, 3, 32'hDEADBEEF, 0, 0, 0, 32'h0, 3, 0, 6, 1, 7'h33, 0, 0, 32'hDEADBEEF, 0};
    vecs[3]  = '{32'h00018333, 32'h7, D2, 1, 0, 32'hDEADBEEF, 0, 0, 0, 32'h0, 3, 0, 6, 1, 7'h33, 0, 0, 32'h7, 0};
    vecs[4]  = '{32'h001283B3, D1, D2, 1, 1, 32'hCAFEF00D, 1, 6, 0, 32'h0, 5, 1, 7, 1, 7'h33, 0, 0, D1, 32'hCAFEF00D};
    vecs[5]  = '{32'hFE208EE3, D1, D2, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 1, 2, 29, 0, 7'h63, 0, 1, D1, D2};
    vecs[6]  = '{32'h000282B7, D1, D2, 0, 0, 0, 1, 5, 0, 32'h00028000, 5, 0, 5, 1, 7'h37, 0, 0, D1, 0};
    vecs[7]  = '{32'h008000EF, D1, D2, 0, 0, 0, 0, 0, 0, 32'h8, 0, 8, 1, 1, 7'h6F, 0, 0, 0, D2};
    vecs[8]  = '{32'hFF9FF0EF, D1, D2, 0, 0, 0, 1, 31, 0, 32'hFFFFFFF8, 31, 25, 1, 1, 7'h6F, 7, 1, D1, D2};
    vecs[9]  = '{32'hFFFFF517, D1, D2, 0, 0, 0, 0, 0, 0, 32'hFFFFF000, 31, 31, 10, 1, 7'h17, 7, 1, D1, D2};
    vecs[10] = '{32'hFFF12403, D1, D2, 0, 0, 0, 1, 31, 0, 32'hFFFFFFFF, 2, 31, 8, 1, 7'h03, 2, 1, D1, D2};
    vecs[11] = '{32'h00008067, D1, D2, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 7'h67, 0, 0, D1, 0};
    vecs[12] = '{32'h000002FF, D1, D2, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 5, 0, 7'h7F, 0, 0, 0, 0};
    vecs[13] = '{32'h001283B3, D1, D2, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{32'h0021A423, D1, D2, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[15] = '{32'hFE208EE3, D1, D2, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{32'hFFD08293, D1, D2, 0, 0, 0, 1, 29, 0, 32'hFFFFFFFD, 1, 29, 5, 1, 7'h13, 0, 1, D1, D2};

    rst = 1'b1; flush = 1'b0; id_ready = 1'b1;
    rf_rd1 = D1; rf_rd2 = D2; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    ex_load = 1'b1; ex_rd = 5'd1;
    present(32'hFFD08293, 32'h100);

    // Reset held two cycles with a live, hazarding instruction on the input.
    tick(); tick();
    chk("rst_id_valid", {31'b0, id_valid}, 0);
    chk("rst_id_imm", id_imm, 0);
    chk("rst_id_rd", {27'b0, id_rd}, 0);
    chk("rst_if_ready", {31'b0, if_ready}, 1);
    rst = 1'b0; ex_load = 1'b0;
    tick();
    chk("rel_id_valid", {31'b0, id_valid}, 1);
    chk("rel_id_imm", id_imm, 32'hFFFFFFFD);
    chk("rel_id_pc", id_pc, 32'h100);

    // Backpressure: execute stalls three cycles while sw waits at the input.
    id_ready = 1'b0;
    present(32'h0021A423, 32'h104);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_if_ready", {31'b0, if_ready}, 0);
      tick();
      chk("bp_id_valid", {31'b0, id_valid}, 1);
      chk("bp_id_imm", id_imm, 32'hFFFFFFFD);
      chk("bp_id_rd", {27'b0, id_rd}, 5);
      chk("bp_id_pc", id_pc, 32'h100);
    end
    id_ready = 1'b1;
    #1;
    chk("bp_rel_if_ready", {31'b0, if_ready}, 1);
    tick();
    chk("bp_rel_imm", id_imm, 32'h8);
    chk("bp_rel_rd", {27'b0, id_rd}, 8);
    chk("bp_rel_rw", {31'b0, id_reg_write}, 0);

    // Load-use stall, then release.
    ex_load = 1'b1; ex_rd = 5'd5;
    present(32'h001283B3, 32'h108);
    #1;
    chk("lu_if_ready", {31'b0, if_ready}, 0);
    tick();
    chk("lu_bubble", {31'b0, id_valid}, 0);
    ex_load = 1'b0;
    #1;
    chk("lu_rel_if_ready", {31'b0, if_ready}, 1);
    tick();
    chk("lu_rel_valid", {31'b0, id_valid}, 1);
    chk("lu_rel_rd", {27'b0, id_rd}, 7);
    chk("lu_rel_rs1", {27'b0, id_rs1}, 5);
    ex_load = 1'b1;
    present(32'h000282B7, 32'h10C);
    #1;
    chk("lui_if_ready", {31'b0, if_ready}, 1);
    tick();
    chk("lui_valid", {31'b0, id_valid}, 1);
    chk("lui_imm", id_imm, 32'h00028000);
    ex_load = 1'b0;

    // Flush while the held instruction is stalled by execute.
    id_ready = 1'b0; flush = 1'b1;
    present(32'h00018333, 32'h110);
    #1;
    chk("fl_if_ready", {31'b0, if_ready}, 1);
    tick();
    chk("fl_valid", {31'b0, id_valid}, 0);
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    tick();
    chk("fl_lost", {31'b0, id_valid}, 0);

    // Flush coincident with a load-use hazard.
    present(32'hFFD08293, 32'h114);
    tick();
    chk("fh_pre_valid", {31'b0, id_valid}, 1);
    ex_load = 1'b1; ex_rd = 5'd5; flush = 1'b1;
    present(32'h001283B3, 32'h118);
    #1;
    chk("fh_if_ready", {31'b0, if_ready}, 1);
    tick();
    chk("fh_valid", {31'b0, id_valid}, 0);
    flush = 1'b0; ex_load = 1'b0; if_valid = 1'b0;
    tick();
    chk("fh_lost", {31'b0, id_valid}, 0);

    // Drain with nothing incoming.
    present(32'hFFD08293, 32'h11C);
    tick();
    if_valid = 1'b0;
    tick();
    chk("drain_valid", {31'b0, id_valid}, 0);

    // Table: one vector per cycle, back to back, execute always ready.
    for (int i = 0; i < 17; i++) begin
      present(vecs[i].instr, 32'h1000 + 32'(i * 4));
      rf_rd1 = vecs[i].rd1; rf_rd2 = vecs[i].rd2;
      wb_we = vecs[i].wb_we; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
      ex_load = vecs[i].ex_load; ex_rd = vecs[i].ex_rd;
      #1;
      chk($sformatf("v%0d_if_ready", i), {31'b0, if_ready}, {31'b0, !vecs[i].hz});
      chk($sformatf("v%0d_rf_a1", i), {27'b0, rf_a1}, {27'b0, vecs[i].instr[19:15]});
      tick();
      chk($sformatf("v%0d_id_valid", i), {31'b0, id_valid}, {31'b0, !vecs[i].hz});
      if (!vecs[i].hz) begin
        chk($sformatf("v%0d_imm", i), id_imm, vecs[i].imm);
        chk($sformatf("v%0d_rs1", i), {27'b0, id_rs1}, {27'b0, vecs[i].rs1});
        chk($sformatf("v%0d_rs2", i), {27'b0, id_rs2}, {27'b0, vecs[i].rs2});
        chk($sformatf("v%0d_rd", i), {27'b0, id_rd}, {27'b0, vecs[i].rd});
        chk($sformatf("v%0d_rw", i), {31'b0, id_reg_write}, {31'b0, vecs[i].rw});
        chk($sformatf("v%0d_op", i), {25'b0, id_opcode}, {25'b0, vecs[i].op});
        chk($sformatf("v%0d_f3", i), {29'b0, id_funct3}, {29'b0, vecs[i].f3});
        chk($sformatf("v%0d_f7b5", i), {31'b0, id_funct7b5}, {31'b0, vecs[i].f7});
        chk($sformatf("v%0d_rs1_val", i), id_rs1_val, vecs[i].v1);
        chk($sformatf("v%0d_rs2_val", i), id_rs2_val, vecs[i].v2);
        chk($sformatf("v%0d_pc", i), id_pc, 32'h1000 + 32'(i * 4));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
